// File: rtl/if_stage_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   INSTR_W          : instruction word width
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden
//   PC_INC           : byte increment between sequential instructions
//   fetch_state_e    : FETCH (memory transaction in flight) / HOLD (frozen, buffered word)
package if_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int PC_INC = 4;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_stage_fetch_if.sv
// Instruction-memory read bus between the fetch stage and a multi-cycle memory.
//   mem_req   : read request (master -> slave)
//   mem_addr  : word address, held stable until mem_req & mem_ready (master -> slave)
//   mem_rdata : read data, valid when mem_ready (slave -> master)
//   mem_ready : transaction completes this cycle, may be combinational (slave -> master)
interface if_stage_fetch_if #(
  parameter int ADDR_W = 32
);
  import if_pkg::*;

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/if_stage_fetch_pc_reg.sv
// Program-counter register for the fetch stage.
//   clk, rst  : clock, synchronous active-high reset (pc <= RESET_PC)
//   load      : load load_addr (low two bits forced to zero); wins over inc
//   load_addr : redirect target
//   inc       : advance pc by one instruction
//   pc        : current fetch address
//   pc_plus4  : pc + 4, wrapping modulo 2^ADDR_W
module if_pc_reg import if_pkg::*; #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  assign pc_plus4 = pc + ADDR_W'(PC_INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr & WORD_MASK;
    end else if (inc) begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Issues one word read per instruction, presents instruction and pc+4, and raises
// fetch_stall until a valid instruction is available. EXE redirects that arrive
// while a read is outstanding are remembered and applied when the read completes,
// because an issued read may not be cancelled.
//   clk, rst        : clock, synchronous active-high reset
//   mem             : instruction-memory bus (master side)
//   freeze          : hazard-unit stall; hold current instruction
//   branch_taken    : single-cycle EXE redirect request
//   branch_addr     : redirect target (bits [1:0] ignored)
//   pc_out          : pc+4 for the IF/ID register
//   instruction_out : fetched instruction (0 when not valid)
//   fetch_stall     : 1 = instruction_out not valid, pipeline must freeze
module if_stage_fetch import if_pkg::*; #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  if_stage_fetch_if.master    mem,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_addr,
  output logic [ADDR_W-1:0]   pc_out,
  output logic [INSTR_W-1:0]  instruction_out,
  output logic                fetch_stall
);

  localparam logic [ADDR_W-1:0] WORD_MASK   = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] RESET_PC_P4 = RESET_PC + ADDR_W'(PC_INC);

  fetch_state_e       state, next_state;
  logic [INSTR_W-1:0] ibuf;
  logic               redir_pend;
  logic [ADDR_W-1:0]  redir_tgt;

  logic [ADDR_W-1:0]  pc, pc_plus4;
  logic               pc_load, pc_inc;
  logic [ADDR_W-1:0]  pc_tgt;
  logic               ibuf_we, redir_set, redir_clr;
  logic               req_c, stall_c;
  logic [INSTR_W-1:0] instr_c;

  if_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (pc_tgt),
    .inc       (pc_inc),
    .pc        (pc),
    .pc_plus4  (pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      ibuf       <= '0;
      redir_pend <= 1'b0;
      redir_tgt  <= '0;
    end else begin
      state <= next_state;
      if (ibuf_we) begin
        ibuf <= mem.mem_rdata;
      end
      if (redir_set) begin
        redir_pend <= 1'b1;
        redir_tgt  <= branch_addr & WORD_MASK;
      end else if (redir_clr) begin
        redir_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state = state;
    req_c      = 1'b0;
    instr_c    = '0;
    stall_c    = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_tgt     = branch_addr;
    ibuf_we    = 1'b0;
    redir_set  = 1'b0;
    redir_clr  = 1'b0;

    case (state)
      FETCH: begin
        req_c = 1'b1;
        if (mem.mem_ready) begin
          if (branch_taken) begin
            // Fresh redirect supersedes any remembered one.
            pc_load   = 1'b1;
            redir_clr = 1'b1;
          end else if (redir_pend) begin
            // Completed read was for the wrong path; drop it and go to the target.
            pc_load   = 1'b1;
            pc_tgt    = redir_tgt;
            redir_clr = 1'b1;
            stall_c   = 1'b1;
          end else begin
            instr_c = mem.mem_rdata;
            if (freeze) begin
              ibuf_we    = 1'b1;
              next_state = HOLD;
            end else begin
              pc_inc = 1'b1;
            end
          end
        end else begin
          // Address must stay put while the read is outstanding, so only record the redirect.
          redir_set = branch_taken;
          stall_c   = ~branch_taken;
        end
      end
      HOLD: begin
        instr_c = ibuf;
        if (branch_taken) begin
          pc_load    = 1'b1;
          next_state = FETCH;
        end else if (!freeze) begin
          pc_inc     = 1'b1;
          next_state = FETCH;
        end
      end
      default: begin
        next_state = FETCH;
      end
    endcase
  end

  assign mem.mem_req      = rst ? 1'b0 : req_c;
  assign mem.mem_addr     = pc;
  assign instruction_out  = rst ? '0 : instr_c;
  assign fetch_stall      = rst ? 1'b0 : stall_c;
  assign pc_out           = rst ? RESET_PC_P4 : pc_plus4;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: a memory responder with configurable wait states, a
// queue holding the address of the next instruction the pipeline should accept,
// and a monitor that pops and compares whenever the stage delivers an instruction.
module tb_if_stage_fetch;
  import if_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        fetch_stall;

  if_stage_fetch_if #(.ADDR_W(32)) bus();

  if_stage_fetch #(.ADDR_W(32), .RESET_PC(RPC)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem             (bus),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .fetch_stall     (fetch_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int consumed = 0;
  int mode = 0;      // 0: no wait, 1: 2 waits, 2: random 0..3, 3: 20 waits
  int wait_cnt = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a >> 2) + 32'd100;
  endfunction

  function automatic int pick();
    case (mode)
      0:       return 0;
      1:       return 2;
      2:       return int'($urandom_range(0, 3));
      default: return 20;
    endcase
  endfunction

  // Memory model: word k holds k+100, ready after wait_cnt idle cycles.
  assign bus.mem_rdata = word(bus.mem_addr);
  assign bus.mem_ready = bus.mem_req && (wait_cnt == 0);

  always @(posedge clk) begin
    if (rst) wait_cnt <= pick();
    else if (bus.mem_req && bus.mem_ready) wait_cnt <= pick();
    else if (bus.mem_req && wait_cnt > 0) wait_cnt <= wait_cnt - 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: next accepted instruction is the previous one +4, unless a
  // redirect happened since, in which case it is the latest target.
  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(RPC);
  endtask

  task automatic model_branch(input logic [31:0] a);
    exp_q.delete();
    exp_q.push_back({a[31:2], 2'b00});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic        hold_chk = 1'b0;
  logic        pend_chk = 1'b0;
  logic [31:0] prev_instr = '0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      hold_chk <= 1'b0;
      pend_chk <= 1'b0;
    end else begin
      if (branch_taken) chk("stall_with_branch", 32'(fetch_stall), 32'd0);
      if (pend_chk) begin
        chk("req_held", 32'(bus.mem_req), 32'd1);
        chk("addr_stable", bus.mem_addr, prev_addr);
      end
      if (hold_chk) begin
        chk("hold_req", 32'(bus.mem_req), 32'd0);
        chk("hold_stall", 32'(fetch_stall), 32'd0);
        chk("hold_instr", instruction_out, prev_instr);
      end
      if (!fetch_stall && !freeze && !branch_taken) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL accept_unexpected: got pc_out %h expected no instruction", pc_out);
        end else begin
          chk("accept_pc_out", pc_out, exp_q[0] + 32'd4);
          chk("accept_instr", instruction_out, word(exp_q[0]));
          consumed++;
          if (exp_q.size() == 1) exp_q.push_back(exp_q[0] + 32'd4);
          void'(exp_q.pop_front());
        end
      end
      pend_chk   <= bus.mem_req && !bus.mem_ready;
      prev_addr  <= bus.mem_addr;
      hold_chk   <= !fetch_stall && freeze && !branch_taken;
      prev_instr <= instruction_out;
    end
  end

  initial begin
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_addr = '0;
    mode = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_instr", instruction_out, 32'd0);
    chk("rst_stall", 32'(fetch_stall), 32'd0);
    chk("rst_pc_out", pc_out, RPC + 32'd4);
    step();
    rst = 1'b0;

    // Zero-wait streaming.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("zw_instr", instruction_out, 32'(k + 100));
      chk("zw_pc_out", pc_out, 32'(4 * (k + 1)));
      chk("zw_stall", 32'(fetch_stall), 32'd0);
      step();
    end

    // Two wait states per read: stall exactly on the non-ready cycles.
    mode = 1;
    repeat (3) step();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("ws_stall", 32'(fetch_stall), 32'(!bus.mem_ready));
      step();
    end

    // Redirect coincident with completion while frozen: no HOLD entry.
    mode = 0;
    repeat (4) step();
    branch_taken = 1'b1;
    branch_addr = 32'h0000_0200;
    freeze = 1'b1;
    model_branch(branch_addr);
    @(negedge clk);
    chk("brc_stall", 32'(fetch_stall), 32'd0);
    chk("brc_instr", instruction_out, 32'd0);
    step();
    branch_taken = 1'b0;
    freeze = 1'b0;
    @(negedge clk);
    chk("brc_next_req", 32'(bus.mem_req), 32'd1);
    chk("brc_next_addr", bus.mem_addr, 32'h0000_0200);
    step();

    // Reset during a long read with a redirect pending.
    mode = 3;
    repeat (3) step();
    branch_taken = 1'b1;
    branch_addr = 32'h0000_0300;
    model_branch(branch_addr);
    step();
    branch_taken = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    mode = 0;
    model_reset();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_addr", bus.mem_addr, RPC);
    chk("rstmid_instr", instruction_out, word(RPC));
    chk("rstmid_stall", 32'(fetch_stall), 32'd0);
    step();

    // Redirect to the top word (unaligned bits ignored); pc_out wraps to 0.
    branch_taken = 1'b1;
    branch_addr = 32'hFFFF_FFFE;
    model_branch(branch_addr);
    step();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("wrap_addr", bus.mem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_out", pc_out, 32'h0000_0000);
    chk("wrap_instr", instruction_out, word(32'hFFFF_FFFC));
    step();
    @(negedge clk);
    chk("wrap_next_addr", bus.mem_addr, 32'h0000_0000);
    step();

    // Randomized traffic: wait states, freezes and redirects.
    mode = 2;
    for (int c = 0; c < 3000; c++) begin
      freeze = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        branch_taken = 1'b1;
        branch_addr = $urandom;
        model_branch(branch_addr);
      end else begin
        branch_taken = 1'b0;
      end
      step();
    end
    branch_taken = 1'b0;
    freeze = 1'b0;
    repeat (20) step();

    checks++;
    if (consumed < 300) begin
      errors++;
      $display("FAIL throughput: got %0d accepted instructions expected at least 300", consumed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
